// File: rtl/phasemeter_lock_sequencer_pkg.sv
// Shared types, widths and the saturating magnitude helper for the phasemeter lock sequencer.
package phasemeter_lock_sequencer_pkg;

  localparam int unsigned MAG_BITS = 16;
  localparam int unsigned MAG_W    = MAG_BITS + 1;
  localparam int unsigned THRESH_W = 16;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DWELL   = 3'd3,
    ST_ACQUIRE = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_FAIL    = 3'd6
  } state_e;

  typedef struct packed {
    logic hit;
    logic inlock;
  } det_t;

  typedef struct packed {
    logic [THRESH_W-1:0] steps;
    logic [THRESH_W-1:0] amp_thresh;
    logic [THRESH_W-1:0] err_thresh;
  } cfg_t;

  // Two's-complement magnitude; the most negative code clamps to the most positive one.
  function automatic logic [MAG_BITS-1:0] sat_abs(input logic [MAG_BITS-1:0] x);
    logic [MAG_BITS-1:0] neg;
    neg = ~x + MAG_BITS'(1);
    if (x == {1'b1, {(MAG_BITS-1){1'b0}}}) return {1'b0, {(MAG_BITS-1){1'b1}}};
    return x[MAG_BITS-1] ? neg : x;
  endfunction

endpackage

// File: rtl/phasemeter_lock_sequencer_if.sv
// Sequencer <-> phasemeter channel: guess load / loop enable out, decimated I/Q metric in.
interface phasemeter_lock_sequencer_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] guess_tdata;
  logic              guess_tvalid;
  logic              pm_rst;
  logic              pm_en;
  logic [DATA_W-1:0] metric_i;
  logic [DATA_W-1:0] metric_q;
  logic              metric_valid;

  modport master (
    output guess_tdata, guess_tvalid, pm_rst, pm_en,
    input  metric_i, metric_q, metric_valid
  );

  modport slave (
    input  guess_tdata, guess_tvalid, pm_rst, pm_en,
    output metric_i, metric_q, metric_valid
  );
endinterface

// File: rtl/phasemeter_lock_sequencer_lock_detector.sv
// Registered beat-note detector: |I|+|Q| against amp threshold, |I| against loop-error ceiling.
module phasemeter_lock_sequencer_lock_detector
  import phasemeter_lock_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   metric_i,
  input  logic [DATA_W-1:0]   metric_q,
  input  logic                metric_valid,
  input  logic [THRESH_W-1:0] amp_thresh,
  input  logic [THRESH_W-1:0] err_thresh,
  output logic                det_valid,
  output det_t                det
);

  logic [MAG_BITS-1:0] abs_i_c;
  logic [MAG_BITS-1:0] abs_q_c;
  logic [MAG_W-1:0]    mag_c;
  logic                hit_c;
  logic                unused_lsbs_c;

  assign abs_i_c       = sat_abs(metric_i[DATA_W-1 -: MAG_BITS]);
  assign abs_q_c       = sat_abs(metric_q[DATA_W-1 -: MAG_BITS]);
  assign mag_c         = MAG_W'(abs_i_c) + MAG_W'(abs_q_c);
  assign hit_c         = mag_c >= MAG_W'(amp_thresh);
  assign unused_lsbs_c = ^{metric_i[DATA_W-MAG_BITS-1:0], metric_q[DATA_W-MAG_BITS-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_valid <= 1'b0;
      det       <= '0;
    end else begin
      det_valid <= metric_valid;
      if (metric_valid) begin
        det.hit    <= hit_c;
        det.inlock <= hit_c && (abs_i_c <= err_thresh);
      end
    end
  end

endmodule

// File: rtl/phasemeter_lock_sequencer.sv
// Sweep / acquire / lock / relock controller for one phasemeter channel.
module phasemeter_lock_sequencer
  import phasemeter_lock_sequencer_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned PM_RST_CYCLES    = 4,
  parameter int unsigned SETTLE_SAMPLES   = 8,
  parameter int unsigned ACQ_SAMPLES      = 16,
  parameter int unsigned LOSS_SAMPLES     = 32,
  parameter int unsigned MAX_PASSES       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [AXIS_TDATA_WIDTH-1:0] sweep_start,
  input  logic [AXIS_TDATA_WIDTH-1:0] sweep_step,
  input  logic [THRESH_W-1:0]         sweep_steps,
  input  logic [THRESH_W-1:0]         amp_thresh,
  input  logic [THRESH_W-1:0]         err_thresh,
  phasemeter_lock_sequencer_if.master pm,
  output logic                        locked,
  output logic                        fail,
  output logic [STATE_W-1:0]          state_o,
  output logic [THRESH_W-1:0]         relock_count
);

  localparam int unsigned DW          = AXIS_TDATA_WIDTH;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned PASS_W      = 8;
  localparam int unsigned ACQ_TIMEOUT = 64 * ACQ_SAMPLES;
  localparam int unsigned TMO_W       = $clog2(ACQ_TIMEOUT + 1);

  state_e              state, state_nxt;
  logic [DW-1:0]       guess, guess_nxt;
  logic [DW-1:0]       start_r, start_nxt;
  logic [DW-1:0]       step_r, step_nxt;
  cfg_t                cfg, cfg_nxt;
  logic [THRESH_W-1:0] step_idx, step_idx_nxt;
  logic [PASS_W-1:0]   pass, pass_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [TMO_W-1:0]    tmo, tmo_nxt;
  logic [THRESH_W-1:0] relock_nxt;
  logic                miss_c;
  logic                det_valid;
  det_t                det;

  phasemeter_lock_sequencer_lock_detector #(.DATA_W(DW)) u_det (
    .clk          (clk),
    .rst          (rst),
    .metric_i     (pm.metric_i),
    .metric_q     (pm.metric_q),
    .metric_valid (pm.metric_valid),
    .amp_thresh   (cfg.amp_thresh),
    .err_thresh   (cfg.err_thresh),
    .det_valid    (det_valid),
    .det          (det)
  );

  // Next-state and counter logic; each detector strobe is consumed by the state it arrives in.
  always_comb begin
    state_nxt    = state;
    guess_nxt    = guess;
    start_nxt    = start_r;
    step_nxt     = step_r;
    cfg_nxt      = cfg;
    step_idx_nxt = step_idx;
    pass_nxt     = pass;
    cnt_nxt      = cnt;
    tmo_nxt      = tmo;
    relock_nxt   = relock_count;
    miss_c       = 1'b0;

    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_FAIL: begin
          if (start) begin
            start_nxt    = sweep_start;
            step_nxt     = sweep_step;
            cfg_nxt      = '{steps:      (sweep_steps == '0) ? THRESH_W'(1) : sweep_steps,
                             amp_thresh: amp_thresh,
                             err_thresh: err_thresh};
            guess_nxt    = sweep_start;
            step_idx_nxt = '0;
            pass_nxt     = '0;
            relock_nxt   = '0;
            cnt_nxt      = '0;
            state_nxt    = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cnt == CNT_W'(PM_RST_CYCLES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_SETTLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (det_valid) begin
            if (cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
              cnt_nxt   = '0;
              state_nxt = ST_DWELL;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        ST_DWELL: begin
          if (det_valid) begin
            if (det.hit) begin
              cnt_nxt   = '0;
              tmo_nxt   = '0;
              state_nxt = ST_ACQUIRE;
            end else begin
              miss_c = 1'b1;
            end
          end
        end
        ST_ACQUIRE: begin
          if (det_valid) begin
            tmo_nxt = tmo + TMO_W'(1);
            cnt_nxt = det.inlock ? cnt + CNT_W'(1) : '0;
            if (det.inlock && cnt == CNT_W'(ACQ_SAMPLES - 1)) begin
              cnt_nxt   = '0;
              state_nxt = ST_LOCKED;
            end else if (tmo == TMO_W'(ACQ_TIMEOUT - 1)) begin
              miss_c = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (det_valid) begin
            if (det.inlock) begin
              cnt_nxt = '0;
            end else if (cnt == CNT_W'(LOSS_SAMPLES - 1)) begin
              cnt_nxt   = '0;
              state_nxt = ST_LOAD;
              if (relock_count != '1) relock_nxt = relock_count + THRESH_W'(1);
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase

      // A miss advances the sweep; the last step of a pass wraps back to the start word.
      if (miss_c) begin
        cnt_nxt   = '0;
        state_nxt = ST_LOAD;
        if (step_idx == cfg.steps - THRESH_W'(1)) begin
          guess_nxt    = start_r;
          step_idx_nxt = '0;
          pass_nxt     = pass + PASS_W'(1);
          if (MAX_PASSES != 0 && pass_nxt == PASS_W'(MAX_PASSES)) state_nxt = ST_FAIL;
        end else begin
          guess_nxt    = guess + step_r;
          step_idx_nxt = step_idx + THRESH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      guess           <= '0;
      start_r         <= '0;
      step_r          <= '0;
      cfg             <= '0;
      step_idx        <= '0;
      pass            <= '0;
      cnt             <= '0;
      tmo             <= '0;
      relock_count    <= '0;
      pm.guess_tvalid <= 1'b0;
      pm.pm_rst       <= 1'b1;
      pm.pm_en        <= 1'b0;
      locked          <= 1'b0;
      fail            <= 1'b0;
    end else begin
      state           <= state_nxt;
      guess           <= guess_nxt;
      start_r         <= start_nxt;
      step_r          <= step_nxt;
      cfg             <= cfg_nxt;
      step_idx        <= step_idx_nxt;
      pass            <= pass_nxt;
      cnt             <= cnt_nxt;
      tmo             <= tmo_nxt;
      relock_count    <= relock_nxt;
      pm.guess_tvalid <= (state_nxt != ST_IDLE);
      pm.pm_rst       <= (state_nxt inside {ST_IDLE, ST_LOAD, ST_FAIL});
      pm.pm_en        <= (state_nxt inside {ST_ACQUIRE, ST_LOCKED});
      locked          <= (state_nxt == ST_LOCKED);
      fail            <= (state_nxt == ST_FAIL);
    end
  end

  assign pm.guess_tdata = guess;
  assign state_o        = state;

endmodule

// File: tb/tb_phasemeter_lock_sequencer.sv
// Directed self-checking bench for the phasemeter lock sequencer.
module tb_phasemeter_lock_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_SETTLE = 3'd2,
                         S_ACQ = 3'd4, S_LOCKED = 3'd5, S_FAIL = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] sweep_start = '0;
  logic [31:0] sweep_step = '0;
  logic [15:0] sweep_steps = '0;
  logic [15:0] amp_thresh = '0;
  logic [15:0] err_thresh = '0;
  logic        locked, fail;
  logic [2:0]  state_o;
  logic [15:0] relock_count;
  int          checks = 0;
  int          errors = 0;

  phasemeter_lock_sequencer_if #(.DATA_W(32)) pm_if ();

  phasemeter_lock_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .sweep_start  (sweep_start),
    .sweep_step   (sweep_step),
    .sweep_steps  (sweep_steps),
    .amp_thresh   (amp_thresh),
    .err_thresh   (err_thresh),
    .pm           (pm_if),
    .locked       (locked),
    .fail         (fail),
    .state_o      (state_o),
    .relock_count (relock_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic [15:0] i16, input logic [15:0] q16);
    @(negedge clk);
    pm_if.metric_i     = {i16, 16'h0};
    pm_if.metric_q     = {q16, 16'h0};
    pm_if.metric_valid = 1'b1;
    @(negedge clk);
    pm_if.metric_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (state_o === s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Let the current guess settle, then present one dwell sample.
  task automatic run_point(input logic [15:0] i16, input logic [15:0] q16);
    bit ok;
    wait_state(S_SETTLE, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL settle_wait: state %0d, SETTLE never reached", state_o); end
    for (int n = 0; n < 8; n++) strobe(16'h0, 16'h0);
    strobe(i16, q16);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_reset();
    pm_if.metric_i = '0; pm_if.metric_q = '0; pm_if.metric_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_o); end
    checks++; if (pm_if.guess_tdata !== 32'h0) begin errors++; $display("FAIL rst_guess: got %0h expected 0", pm_if.guess_tdata); end
    checks++; if (pm_if.guess_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", pm_if.guess_tvalid); end
    checks++; if (pm_if.pm_rst !== 1'b1) begin errors++; $display("FAIL rst_pm_rst: got %b expected 1", pm_if.pm_rst); end
    checks++; if ({pm_if.pm_en, locked, fail} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {pm_if.pm_en, locked, fail}); end
    checks++; if (relock_count !== 16'h0) begin errors++; $display("FAIL rst_relock: got %0d expected 0", relock_count); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state_o); end
  endtask

  task automatic test_sweep_hit();
    int rst_cycles;
    sweep_start = 32'd100; sweep_step = 32'd10; sweep_steps = 16'd4;
    amp_thresh = 16'd1000; err_thresh = 16'd500;
    pulse_start();
    checks++; if (state_o !== S_LOAD) begin errors++; $display("FAIL t1_load: got %0d expected 1", state_o); end
    checks++; if (pm_if.guess_tdata !== 32'd100) begin errors++; $display("FAIL t1_guess0: got %0d expected 100", pm_if.guess_tdata); end
    checks++; if ({pm_if.pm_rst, pm_if.guess_tvalid} !== 2'b11) begin errors++; $display("FAIL t1_rst_tvalid: got %b expected 11", {pm_if.pm_rst, pm_if.guess_tvalid}); end
    sweep_step = 32'd999;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        checks++; if (state_o !== S_LOAD) begin errors++; $display("FAIL t1_step_state%0d: got %0d expected 1", k, state_o); end
        checks++; if (pm_if.guess_tdata !== 32'(100 + 10 * k)) begin errors++; $display("FAIL t1_guess%0d: got %0d expected %0d", k, pm_if.guess_tdata, 100 + 10 * k); end
      end
      if (k == 1) begin
        rst_cycles = 0;
        for (int n = 0; n < 20 && pm_if.pm_rst === 1'b1; n++) begin
          rst_cycles++;
          @(negedge clk);
        end
        checks++; if (rst_cycles != 4) begin errors++; $display("FAIL t1_pm_rst_len: got %0d expected 4", rst_cycles); end
      end
      run_point((k == 2) ? 16'd200 : 16'd0, (k == 2) ? 16'd1000 : 16'd0);
    end
    checks++; if (state_o !== S_ACQ) begin errors++; $display("FAIL t1_acquire: got %0d expected 4", state_o); end
    checks++; if ({pm_if.pm_en, pm_if.pm_rst} !== 2'b10) begin errors++; $display("FAIL t1_en: got %b expected 10", {pm_if.pm_en, pm_if.pm_rst}); end
  endtask

  task automatic test_lock_relock();
    for (int n = 0; n < 15; n++) strobe(16'd200, 16'd1000);
    checks++; if ({state_o, locked} !== {S_ACQ, 1'b0}) begin errors++; $display("FAIL t2_pre_lock: got %0d/%b expected 4/0", state_o, locked); end
    strobe(16'd200, 16'd1000);
    checks++; if ({state_o, locked, pm_if.pm_en} !== {S_LOCKED, 2'b11}) begin errors++; $display("FAIL t2_locked: got %0d/%b/%b expected 5/1/1", state_o, locked, pm_if.pm_en); end
    for (int n = 0; n < 31; n++) strobe(16'd0, 16'd0);
    strobe(16'd200, 16'd1000);
    for (int n = 0; n < 31; n++) strobe(16'd0, 16'd0);
    checks++; if ({state_o, relock_count} !== {S_LOCKED, 16'd0}) begin errors++; $display("FAIL t2_hold: got %0d/%0d expected 5/0", state_o, relock_count); end
    strobe(16'd0, 16'd0);
    checks++; if (state_o !== S_LOAD) begin errors++; $display("FAIL t2_relock_state: got %0d expected 1", state_o); end
    checks++; if (relock_count !== 16'd1) begin errors++; $display("FAIL t2_relock_count: got %0d expected 1", relock_count); end
    checks++; if (pm_if.guess_tdata !== 32'd120) begin errors++; $display("FAIL t2_relock_guess: got %0d expected 120", pm_if.guess_tdata); end
    checks++; if ({locked, pm_if.pm_en, pm_if.pm_rst} !== 3'b001) begin errors++; $display("FAIL t2_relock_flags: got %b expected 001", {locked, pm_if.pm_en, pm_if.pm_rst}); end
  endtask

  task automatic test_fail();
    pulse_abort();
    checks++; if ({state_o, pm_if.guess_tvalid, pm_if.pm_rst} !== {S_IDLE, 2'b01}) begin errors++; $display("FAIL t3_abort: got %0d/%b/%b expected 0/0/1", state_o, pm_if.guess_tvalid, pm_if.pm_rst); end
    sweep_start = 32'd100; sweep_step = 32'd10; sweep_steps = 16'd4;
    pulse_start();
    checks++; if (relock_count !== 16'd0) begin errors++; $display("FAIL t3_relock_clr: got %0d expected 0", relock_count); end
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (pm_if.guess_tdata !== 32'(100 + 10 * k)) begin errors++; $display("FAIL t3_guess_p%0d_k%0d: got %0d expected %0d", p, k, pm_if.guess_tdata, 100 + 10 * k); end
        run_point(16'd0, 16'd0);
      end
    end
    checks++; if ({state_o, fail} !== {S_FAIL, 1'b1}) begin errors++; $display("FAIL t3_fail: got %0d/%b expected 6/1", state_o, fail); end
    checks++; if ({pm_if.pm_rst, pm_if.pm_en, locked} !== 3'b100) begin errors++; $display("FAIL t3_fail_flags: got %b expected 100", {pm_if.pm_rst, pm_if.pm_en, locked}); end
  endtask

  task automatic test_wrap();
    sweep_start = 32'hFFFF_FFF8; sweep_step = 32'd16;
    pulse_start();
    checks++; if ({state_o, fail} !== {S_LOAD, 1'b0}) begin errors++; $display("FAIL t4_restart: got %0d/%b expected 1/0", state_o, fail); end
    checks++; if (pm_if.guess_tdata !== 32'hFFFF_FFF8) begin errors++; $display("FAIL t4_guess0: got %h expected fffffff8", pm_if.guess_tdata); end
    run_point(16'd0, 16'd0);
    checks++; if (pm_if.guess_tdata !== 32'h0000_0008) begin errors++; $display("FAIL t4_wrap: got %h expected 00000008", pm_if.guess_tdata); end
    pulse_abort();
    sweep_start = 32'h20; sweep_step = 32'hFFFF_FFF0;
    pulse_start();
    run_point(16'd0, 16'd0);
    checks++; if (pm_if.guess_tdata !== 32'h10) begin errors++; $display("FAIL t4_neg1: got %h expected 00000010", pm_if.guess_tdata); end
    run_point(16'd0, 16'd0);
    checks++; if (pm_if.guess_tdata !== 32'h0) begin errors++; $display("FAIL t4_neg2: got %h expected 00000000", pm_if.guess_tdata); end
  endtask

  task automatic test_magnitude();
    pulse_abort();
    sweep_start = 32'd0; sweep_step = 32'd1; sweep_steps = 16'd8;
    amp_thresh = 16'h8000; err_thresh = 16'hFFFF;
    pulse_start();
    run_point(16'h8000, 16'h0000);
    checks++; if ({state_o, pm_if.guess_tdata} !== {S_LOAD, 32'd1}) begin errors++; $display("FAIL t5_sat_abs: got %0d/%0d expected 1/1", state_o, pm_if.guess_tdata); end
    pulse_abort();
    amp_thresh = 16'h7FFF;
    pulse_start();
    run_point(16'h8000, 16'h0000);
    checks++; if (state_o !== S_ACQ) begin errors++; $display("FAIL t5_sat_hit: got %0d expected 4", state_o); end
    pulse_abort();
    amp_thresh = 16'd200;
    pulse_start();
    run_point(16'd100, 16'hFF9D);
    checks++; if ({state_o, pm_if.guess_tdata} !== {S_LOAD, 32'd1}) begin errors++; $display("FAIL t5_below: got %0d/%0d expected 1/1", state_o, pm_if.guess_tdata); end
    run_point(16'd100, 16'hFF9C);
    checks++; if (state_o !== S_ACQ) begin errors++; $display("FAIL t5_equal: got %0d expected 4", state_o); end
  endtask

  task automatic test_abort_and_async_reset();
    for (int n = 0; n < 16; n++) strobe(16'd100, 16'hFF9C);
    checks++; if ({state_o, locked} !== {S_LOCKED, 1'b1}) begin errors++; $display("FAIL t6_locked: got %0d/%b expected 5/1", state_o, locked); end
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    checks++; if ({state_o, pm_if.pm_en, locked} !== {S_IDLE, 2'b00}) begin errors++; $display("FAIL t6_abort_start: got %0d/%b/%b expected 0/0/0", state_o, pm_if.pm_en, locked); end
    pulse_start();
    run_point(16'd100, 16'hFF9C);
    for (int n = 0; n < 3; n++) strobe(16'd100, 16'hFF9C);
    checks++; if (state_o !== S_ACQ) begin errors++; $display("FAIL t6_mid_acq: got %0d expected 4", state_o); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({state_o, pm_if.guess_tdata} !== {S_IDLE, 32'h0}) begin errors++; $display("FAIL t6_arst_state: got %0d/%h expected 0/0", state_o, pm_if.guess_tdata); end
    checks++; if ({pm_if.guess_tvalid, pm_if.pm_rst, pm_if.pm_en, locked, fail} !== 5'b01000) begin errors++; $display("FAIL t6_arst_flags: got %b expected 01000", {pm_if.guess_tvalid, pm_if.pm_rst, pm_if.pm_en, locked, fail}); end
    checks++; if (relock_count !== 16'h0) begin errors++; $display("FAIL t6_arst_relock: got %0d expected 0", relock_count); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sweep_hit();
    test_lock_relock();
    test_fail();
    test_wrap();
    test_magnitude();
    test_abort_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
